// File: rtl/contador_palabras_if.sv
// Bus for contador_palabras: per-FIFO pop/empty strobes plus the IDLE-gated
// request/index handshake and its one-cycle response.
interface contador_palabras_if #(
    parameter int CNT_WIDTH = 5,
    parameter int IDX_WIDTH = 2
);
    logic                 pop4;
    logic                 pop5;
    logic                 pop6;
    logic                 pop7;
    logic                 empty4;
    logic                 empty5;
    logic                 empty6;
    logic                 empty7;
    logic                 IDLE;
    logic                 req;
    logic [IDX_WIDTH-1:0] idx;
    logic                 valid_contador;
    logic [CNT_WIDTH-1:0] contador_out;

    modport master (
        output pop4, pop5, pop6, pop7,
        output empty4, empty5, empty6, empty7,
        output IDLE, req, idx,
        input  valid_contador, contador_out
    );

    modport slave (
        input  pop4, pop5, pop6, pop7,
        input  empty4, empty5, empty6, empty7,
        input  IDLE, req, idx,
        output valid_contador, contador_out
    );
endinterface

// File: rtl/contador_palabras.sv
// Per-FIFO popped-word counters for output FIFOs 4..7 with an IDLE-gated read handshake.
// Define COUNTER_SAT_EN to make counters saturate instead of wrapping.
module contador_palabras #(
    parameter int CNT_WIDTH = 5,
    parameter int IDX_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    contador_palabras_if.slave   bus
);
    localparam int NFIFO = 4;

    typedef enum logic [1:0] {
        COUNT = 2'd0,
        READY = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t                          state_q;
    state_t                          state_d;
    logic                            req_q;
    logic                            req_rise;
    logic                            capture;
    logic [CNT_WIDTH-1:0]            contador_q;
    logic [CNT_WIDTH-1:0]            contador_d;
    logic [NFIFO-1:0]                pop_vec;
    logic [NFIFO-1:0]                empty_vec;
    logic [NFIFO-1:0][CNT_WIDTH-1:0] cnt_vec;

    assign pop_vec   = {bus.pop7, bus.pop6, bus.pop5, bus.pop4};
    assign empty_vec = {bus.empty7, bus.empty6, bus.empty5, bus.empty4};

    // One counter per FIFO; a pop against an empty FIFO moves no word.
    generate
        for (genvar gi = 0; gi < NFIFO; gi++) begin : g_cnt
            logic [CNT_WIDTH-1:0] cnt_q;
            logic [CNT_WIDTH-1:0] cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (pop_vec[gi] && !empty_vec[gi]) begin
`ifdef COUNTER_SAT_EN
                    if (cnt_q != {CNT_WIDTH{1'b1}}) begin
                        cnt_d = cnt_q + 1'b1;
                    end
`else
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign cnt_vec[gi] = cnt_q;
        end
    endgenerate

    assign req_rise = bus.req & ~req_q;
    assign capture  = (state_q == READY) && bus.IDLE && req_rise;

    // The captured value is the pre-increment count of this cycle.
    assign contador_d = capture ? cnt_vec[bus.idx] : contador_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= COUNT;
            req_q      <= 1'b0;
            contador_q <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= bus.req;
            contador_q <= contador_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            COUNT: begin
                if (bus.IDLE) begin
                    state_d = READY;
                end
            end
            READY: begin
                if (!bus.IDLE) begin
                    state_d = COUNT;
                end else if (req_rise) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = bus.IDLE ? READY : COUNT;
            end
            default: begin
                state_d = COUNT;
            end
        endcase
    end

    // Pulse derives from the state register so an async reset drops it at once.
    always_comb begin
        bus.valid_contador = (state_q == RESP);
        bus.contador_out   = contador_q;
    end
endmodule

// File: tb/tb_contador_palabras.sv
// Randomized and directed check of contador_palabras against a cycle-level
// behavioural model of the counters and the request handshake.
module tb_contador_palabras;
    localparam int CNT_WIDTH = 5;
    localparam int IDX_WIDTH = 2;
    localparam int CNT_MAX   = (1 << CNT_WIDTH) - 1;

    logic clk;
    logic reset;

    contador_palabras_if #(.CNT_WIDTH(CNT_WIDTH), .IDX_WIDTH(IDX_WIDTH)) bus ();

    contador_palabras #(.CNT_WIDTH(CNT_WIDTH), .IDX_WIDTH(IDX_WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int failures  = 0;

    // Reference model state
    int cnt_m [4];
    int out_m;
    bit ready_m;
    bit req_prev_m;
    bit obs_valid;

    task automatic check_eq(input string tag, input int got, input int exp);
        tests_run++;
        if (got != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int bump(input int v);
`ifdef COUNTER_SAT_EN
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
`else
        return (v + 1) % (CNT_MAX + 1);
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) cnt_m[i] = 0;
        out_m      = 0;
        ready_m    = 1'b0;
        req_prev_m = 1'b0;
    endtask

    // Drive one cycle of inputs (called just after a falling edge), predict, compare.
    task automatic step(input logic [3:0] pops, input logic [3:0] empt,
                        input logic idle, input logic rq, input logic [1:0] ix);
        bit exp_resp;
        bus.pop4 = pops[0]; bus.pop5 = pops[1]; bus.pop6 = pops[2]; bus.pop7 = pops[3];
        bus.empty4 = empt[0]; bus.empty5 = empt[1]; bus.empty6 = empt[2]; bus.empty7 = empt[3];
        bus.IDLE = idle;
        bus.req  = rq;
        bus.idx  = ix;

        exp_resp = ready_m && idle && rq && !req_prev_m;
        if (exp_resp) out_m = cnt_m[ix];
        ready_m = idle && !exp_resp;
        for (int i = 0; i < 4; i++) begin
            if (pops[i] && !empt[i]) cnt_m[i] = bump(cnt_m[i]);
        end
        req_prev_m = rq;

        @(posedge clk);
        #1;
        obs_valid = bus.valid_contador;
        check_eq("valid", int'(obs_valid), int'(exp_resp));
        check_eq("out", int'(bus.contador_out), out_m);
        if (obs_valid) $display("[TB] t=%0t response idx=%0d value=%0d", $time, ix, bus.contador_out);
        @(negedge clk);
    endtask

    task automatic read_cnt(input string tag, input logic [1:0] ix, input int exp,
                            input logic [3:0] pops, input logic [3:0] empt);
        step(4'b0, 4'b0, 1'b1, 1'b0, 2'd0);
        step(pops, empt, 1'b1, 1'b1, ix);
        check_eq({tag, "_pulse"}, int'(obs_valid), 1);
        check_eq(tag, int'(bus.contador_out), exp);
        step(4'b0, 4'b0, 1'b1, 1'b0, 2'd0);
        check_eq({tag, "_single"}, int'(obs_valid), 0);
    endtask

    task automatic apply_reset();
        bus.req = 1'b0;
        reset = 1'b0;
        #1;
        check_eq("rst_valid", int'(bus.valid_contador), 0);
        check_eq("rst_out", int'(bus.contador_out), 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int pulses;
        reset = 1'b0;
        bus.pop4 = 0; bus.pop5 = 0; bus.pop6 = 0; bus.pop7 = 0;
        bus.empty4 = 0; bus.empty5 = 0; bus.empty6 = 0; bus.empty7 = 0;
        bus.IDLE = 0; bus.req = 0; bus.idx = '0;
        model_reset();
        @(negedge clk);
        apply_reset();

        // Basic count on FIFO4
        for (int k = 0; k < 6; k++) step(4'b0001, 4'b0, 1'b0, 1'b0, 2'd0);
        read_cnt("basic", 2'd0, 6, 4'b0, 4'b0);

        // Empty guard on FIFO5, then a pop in the same cycle as the capture
        for (int k = 0; k < 5; k++) step(4'b0010, (k >= 3) ? 4'b0010 : 4'b0000, 1'b0, 1'b0, 2'd0);
        read_cnt("empty_guard", 2'd1, 3, 4'b0, 4'b0);
        read_cnt("same_cycle", 2'd1, 3, 4'b0010, 4'b0);
        read_cnt("after_same", 2'd1, 4, 4'b0, 4'b0);

        // Held request yields one pulse
        pulses = 0;
        step(4'b0, 4'b0, 1'b1, 1'b0, 2'd0);
        for (int k = 0; k < 4; k++) begin
            step(4'b0, 4'b0, 1'b1, 1'b1, 2'd0);
            pulses += int'(obs_valid);
        end
        step(4'b0, 4'b0, 1'b1, 1'b0, 2'd0);
        pulses += int'(obs_valid);
        check_eq("hold_pulses", pulses, 1);

        // Request while not idle, and IDLE falling together with the request edge
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            step(4'b0, 4'b0, 1'b0, 1'b1, 2'd0);
            pulses += int'(obs_valid);
            step(4'b0, 4'b0, 1'b0, 1'b0, 2'd0);
            pulses += int'(obs_valid);
        end
        step(4'b0, 4'b0, 1'b1, 1'b0, 2'd0);
        step(4'b0, 4'b0, 1'b0, 1'b1, 2'd0);
        pulses += int'(obs_valid);
        step(4'b0, 4'b0, 1'b0, 1'b0, 2'd0);
        pulses += int'(obs_valid);
        check_eq("noidle_pulses", pulses, 0);

        // Async reset while the response pulse is high
        step(4'b0, 4'b0, 1'b1, 1'b0, 2'd0);
        step(4'b0, 4'b0, 1'b1, 1'b1, 2'd0);
        check_eq("resp_before_rst", int'(bus.valid_contador), 1);
        bus.req = 1'b0;
        bus.IDLE = 1'b0;
        #2;
        apply_reset();
        step(4'b0, 4'b0, 1'b1, 1'b0, 2'd0);
        check_eq("no_replay", int'(obs_valid), 0);
        for (int i = 0; i < 4; i++) read_cnt("post_rst", i[1:0], 0, 4'b0, 4'b0);

        // Wrap or saturate on FIFO7
        for (int k = 0; k < 33; k++) step(4'b1000, 4'b0, 1'b0, 1'b0, 2'd0);
`ifdef COUNTER_SAT_EN
        read_cnt("saturate", 2'd3, 31, 4'b0, 4'b0);
`else
        read_cnt("wrap", 2'd3, 1, 4'b0, 4'b0);
`endif

        // All four FIFOs at once
        @(negedge clk);
        apply_reset();
        for (int c = 0; c < 5; c++) begin
            logic [3:0] m;
            for (int i = 0; i < 4; i++) m[i] = (c < i + 2);
            step(m, 4'b0, 1'b0, 1'b0, 2'd0);
        end
        for (int i = 0; i < 4; i++) read_cnt("all_four", i[1:0], i + 2, 4'b0, 4'b0);

        // Random traffic against the model
        for (int k = 0; k < 600; k++) begin
            logic [3:0] p;
            logic [3:0] e;
            p = 4'($urandom_range(0, 15));
            e = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            step(p, e, ($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)));
        end
        for (int i = 0; i < 4; i++) read_cnt("rand_final", i[1:0], cnt_m[i], 4'b0, 4'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end
endmodule
